// File: rtl/mem_store_pkg.sv
// Shared types and helpers for the byte-serial store path of the MEM stage.
package mem_store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Index of the final byte of a store; reserved size never reaches the bus.
  function automatic logic [1:0] last_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      2'd2:    return data[23:16];
      2'd3:    return data[31:24];
      default: return data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_store_if.sv
// Pipeline-side request and memory-bus write signals of the store path.
interface mem_store_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic [1:0]        size_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_dout_o;
  logic              stall_o;
  logic              done_o;

  modport master (
    output req_i, size_i, addr_i, data_i, mem_gnt_i,
    input  mem_we_o, mem_addr_o, mem_dout_o, stall_o, done_o
  );

  modport slave (
    input  req_i, size_i, addr_i, data_i, mem_gnt_i,
    output mem_we_o, mem_addr_o, mem_dout_o, stall_o, done_o
  );
endinterface

// File: rtl/mem_store.sv
// Turns one SB/SH/SW request into little-endian single-byte bus writes,
// stalling the pipeline until the last byte is granted.
module mem_store
  import mem_store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_store_if.slave bus
);

  state_t            state_r;
  logic [1:0]        cnt_r;
  logic [1:0]        last_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       data_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_dout_r;
  logic              done_r;
  logic [1:0]        cnt_nxt_s;

  assign cnt_nxt_s = cnt_r + 2'd1;

  // Store sequencer: accepts a request in IDLE, then steps one byte per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      last_r     <= 2'd0;
      base_r     <= {ADDR_W{1'b0}};
      data_r     <= 32'd0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_dout_r <= 8'd0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_i) begin
            base_r <= bus.addr_i;
            data_r <= bus.data_i;
            cnt_r  <= 2'd0;
            last_r <= last_of(bus.size_i);
            // A reserved size completes at once without touching the bus.
            if (bus.size_i == SZ_RSVD) begin
              done_r <= 1'b1;
            end else begin
              mem_we_r   <= 1'b1;
              mem_addr_r <= bus.addr_i;
              mem_dout_r <= bus.data_i[7:0];
              state_r    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.mem_gnt_i) begin
            if (cnt_r != last_r) begin
              cnt_r      <= cnt_nxt_s;
              mem_addr_r <= base_r + ADDR_W'(cnt_nxt_s);
              mem_dout_r <= byte_lane(data_r, cnt_nxt_s);
            end else begin
              mem_we_r <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= ST_IDLE;
            end
          end
        end
        default: begin
          mem_we_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we_o   = mem_we_r;
  assign bus.mem_addr_o = mem_addr_r;
  assign bus.mem_dout_o = mem_dout_r;
  assign bus.done_o     = done_r;
  // Stall is combinational so MEM holds the instruction from the acceptance cycle on.
  assign bus.stall_o    = ((state_r == ST_IDLE) && bus.req_i && (bus.size_i != SZ_RSVD))
                        || (state_r == ST_WRITE);

endmodule
